mem_scan_checker: RTL and testbench
===================================

Name: mem_scan_checker

Overview:
- Synthesizable, parametrised memory sweep-and-compare engine.
- Generalises the word-by-word memory check (64 words, byte address = index<<2, count mismatches) into hardware usable for built-in self-test.
- Issues a pipelined sequence of read addresses to a memory under test and a golden source, compares the returned words after a configurable read latency, and reports error count plus first failing index.
- Sits between the instruction/data memory and the test controller; optional halt-on-first-error mode.

Parameters:
DATA_W, 32, width of compared data words
ADDR_W, 32, width of memory byte address
DEPTH, 64, number of words swept per run (>=1)
STRIDE_SHIFT, 2, byte address = base_addr + (index << STRIDE_SHIFT)
RD_LAT, 1, cycles from address issue to valid read data (0 = combinational read)
ERR_W, 16, width of error counter (saturating)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a sweep; ignored while busy
halt_on_err  in  1  sampled with start; 1 = stop at first mismatch
abort  in  1  synchronous abort of a running sweep
base_addr  in  ADDR_W  sampled with start
mem_addr  out  ADDR_W  byte address to memory under test
gold_idx  out  clog2(DEPTH)  word index to golden source
mem_data  in  DATA_W  memory read data, valid RD_LAT cycles after mem_addr
gold_data  in  DATA_W  expected data, same latency as mem_data
busy  out  1  sweep in progress
done  out  1  sweep finished; held until next accepted start
mismatch  out  1  one-cycle pulse per failing compare
err_count  out  ERR_W  mismatches in current/last sweep
first_err_valid  out  1  at least one mismatch seen this sweep
first_err_idx  out  clog2(DEPTH)  index of first mismatch

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM to IDLE; compare pipeline cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE/DONE + start=1: latch base_addr and halt_on_err; clear err_count, first_err_valid, first_err_idx, done; enter ISSUE; busy=1 next cycle.
- ISSUE: each cycle drive index i (0..DEPTH-1), mem_addr = base + (i<<STRIDE_SHIFT) (mod 2^ADDR_W, wrap allowed), gold_idx = i; push {valid,i} into an RD_LAT-deep pipeline. After i=DEPTH-1 go to DRAIN (or straight to DONE when RD_LAT=0).
- Compare: the pipeline entry exiting in cycle t pairs with mem_data/gold_data in cycle t. If they are unequal: mismatch=1 for one cycle, err_count+1 (saturates at 2^ERR_W-1), and if first_err_valid=0, latch the index and set first_err_valid.
- DRAIN: no new issue; compare remaining entries; when the pipeline is empty go to DONE.
- DONE: busy=0, done=1. mem_addr holds its last value. A sweep occupies exactly DEPTH+RD_LAT busy cycles; done rises the cycle after the last compare.
- halt_on_err=1: on the first mismatch, stop issuing, flush remaining pipeline entries without comparing, go to DONE next cycle; err_count=1.
- abort=1 while busy: go to IDLE next cycle; busy=0, done=0, pipeline flushed; counters keep their values. abort in IDLE/DONE has no effect.
- start while busy: ignored. start and abort in the same cycle while busy: abort wins.
- Reset mid-sweep: immediate return to reset values; no done.

Test Plan:
- DEPTH=64, RD_LAT=1, base=0, mem==gold everywhere -> mem_addr 0,4,...,252; busy for 65 cycles; done=1; err_count=0; first_err_valid=0.
- Golden differs at index 5 only -> one mismatch pulse, RD_LAT cycles after mem_addr=0x14; err_count=1; first_err_idx=5.
- Mismatches at 3 and 60, RD_LAT=3, base=0xFFFFFFF0 -> addresses wrap through 0; err_count=2; first_err_idx=3; 67 busy cycles.
- halt_on_err=1, mismatch at 10 -> no index beyond 10+RD_LAT issued; done; err_count=1; first_err_idx=10.
- ERR_W=4, all 64 words mismatch -> err_count saturates at 15; first_err_idx=0.
- Mid-sweep: abort at index 20 -> IDLE, done=0; restart runs a full sweep. rst_n low at index 30 -> all outputs 0 asynchronously. start pulsed while busy -> no restart; sweep length unchanged.

Source files
------------

// File: rtl/mem_scan_checker.sv
// rtl/mem_scan_checker.sv - pipelined memory sweep-and-compare engine for BIST
module mem_scan_checker #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int DEPTH        = 64,
    parameter int STRIDE_SHIFT = 2,
    parameter int RD_LAT       = 1,
    parameter int ERR_W        = 16,
    localparam int IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_on_err,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [IDX_W-1:0]  gold_idx,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] gold_data,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [ERR_W-1:0]  err_count,
    output logic              first_err_valid,
    output logic [IDX_W-1:0]  first_err_idx
);
    localparam logic [IDX_W-1:0]  LAST = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(1) << STRIDE_SHIFT;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [IDX_W-1:0]   r_idx;
    logic               r_halt;
    logic               r_busy;
    logic               r_done;
    logic [ERR_W-1:0]   r_err;
    logic               r_fev;
    logic [IDX_W-1:0]   r_fei;

    logic               w_issue;
    logic               w_exit_v;
    logic [IDX_W-1:0]   w_exit_idx;
    logic               w_rest_empty;
    logic               w_cmp_err;
    logic               w_halt;
    logic               w_flush;

    assign w_issue   = (r_state == S_ISSUE);
    assign w_cmp_err = w_exit_v && (mem_data != gold_data);
    assign w_halt    = w_cmp_err && r_halt;
    assign w_flush   = (abort && (r_state == S_ISSUE || r_state == S_DRAIN)) || w_halt;

    // Index tags travel alongside the outstanding reads so each compare knows its word.
    generate
        if (RD_LAT == 0) begin : g_comb
            assign w_exit_v     = w_issue;
            assign w_exit_idx   = r_idx;
            assign w_rest_empty = 1'b1;
        end else begin : g_pipe
            localparam logic [RD_LAT-1:0] REST_MASK = {RD_LAT{1'b1}} >> 1;
            logic [RD_LAT-1:0] r_pv;
            logic [IDX_W-1:0]  r_pi [RD_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pv <= '0;
                    for (int k = 0; k < RD_LAT; k++) r_pi[k] <= '0;
                end else if (w_flush) begin
                    r_pv <= '0;
                end else begin
                    r_pv[0] <= w_issue;
                    r_pi[0] <= r_idx;
                    for (int k = 1; k < RD_LAT; k++) begin
                        r_pv[k] <= r_pv[k-1];
                        r_pi[k] <= r_pi[k-1];
                    end
                end
            end

            assign w_exit_v     = r_pv[RD_LAT-1];
            assign w_exit_idx   = r_pi[RD_LAT-1];
            assign w_rest_empty = ((r_pv & REST_MASK) == '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_mem_addr <= '0;
            r_idx      <= '0;
            r_halt     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= '0;
            r_fev      <= 1'b0;
            r_fei      <= '0;
        end else begin
            if (w_cmp_err) begin
                if (r_err != {ERR_W{1'b1}}) r_err <= r_err + 1'b1;
                if (!r_fev) begin
                    r_fev <= 1'b1;
                    r_fei <= w_exit_idx;
                end
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_ISSUE;
                        r_mem_addr <= base_addr;
                        r_idx      <= '0;
                        r_halt     <= halt_on_err;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= '0;
                        r_fev      <= 1'b0;
                        r_fei      <= '0;
                    end
                end
                S_ISSUE, S_DRAIN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (w_halt || (r_state == S_DRAIN && w_rest_empty) ||
                                 (r_state == S_ISSUE && r_idx == LAST && RD_LAT == 0)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_state == S_ISSUE) begin
                        if (r_idx == LAST) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_idx      <= r_idx + 1'b1;
                            r_mem_addr <= r_mem_addr + STEP;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_addr        = r_mem_addr;
    assign gold_idx        = r_idx;
    assign busy            = r_busy;
    assign done            = r_done;
    assign mismatch        = w_cmp_err;
    assign err_count       = r_err;
    assign first_err_valid = r_fev;
    assign first_err_idx   = r_fei;
endmodule

// File: tb/tb_mem_scan_checker.sv
// tb/tb_mem_scan_checker.sv - randomized self-checking bench for mem_scan_checker
module tb_mem_scan_checker;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] base = '0;
    bit          sel = 1'b0;

    logic [31:0] memw [DEPTH];
    logic [31:0] gold [DEPTH];

    logic [31:0] addr_a, md_a, gd_a;
    logic [5:0]  gi_a, fei_a;
    logic        busy_a, done_a, mm_a, fev_a;
    logic [15:0] ec_a;

    logic [31:0] addr_b, md_b, gd_b;
    logic [5:0]  gi_b, fei_b;
    logic        busy_b, done_b, mm_b, fev_b;
    logic [3:0]  ec_b;
    logic [31:0] pm_b [3];
    logic [31:0] pg_b [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_scan_checker #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .STRIDE_SHIFT(2),
                       .RD_LAT(1), .ERR_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .halt_on_err(halt),
        .abort(abort & ~sel), .base_addr(base), .mem_addr(addr_a), .gold_idx(gi_a),
        .mem_data(md_a), .gold_data(gd_a), .busy(busy_a), .done(done_a),
        .mismatch(mm_a), .err_count(ec_a), .first_err_valid(fev_a),
        .first_err_idx(fei_a));

    mem_scan_checker #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .STRIDE_SHIFT(2),
                       .RD_LAT(3), .ERR_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .halt_on_err(halt),
        .abort(abort & sel), .base_addr(base), .mem_addr(addr_b), .gold_idx(gi_b),
        .mem_data(md_b), .gold_data(gd_b), .busy(busy_b), .done(done_b),
        .mismatch(mm_b), .err_count(ec_b), .first_err_valid(fev_b),
        .first_err_idx(fei_b));

    // Memories under test: synchronous reads with 1 and 3 cycles of latency.
    always @(posedge clk) begin
        md_a    <= memw[addr_a[7:2]];
        gd_a    <= gold[gi_a];
        pm_b[0] <= memw[addr_b[7:2]];
        pg_b[0] <= gold[gi_b];
        pm_b[1] <= pm_b[0];
        pg_b[1] <= pg_b[0];
        pm_b[2] <= pm_b[1];
        pg_b[2] <= pg_b[1];
    end
    assign md_b = pm_b[2];
    assign gd_b = pg_b[2];

    wire [31:0] o_addr = sel ? addr_b : addr_a;
    wire [5:0]  o_gidx = sel ? gi_b : gi_a;
    wire        o_busy = sel ? busy_b : busy_a;
    wire        o_done = sel ? done_b : done_a;
    wire        o_mm   = sel ? mm_b : mm_a;
    wire [15:0] o_err  = sel ? {12'b0, ec_b} : ec_a;
    wire        o_fev  = sel ? fev_b : fev_a;
    wire [5:0]  o_fei  = sel ? fei_b : fei_a;

    int busy_cnt, addr_bad, pulses, first_pulse, max_idx;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: clean, 1: bad at k1/k2 (negative = unused), 2: all bad, 3: random bad
    task automatic load(input logic [31:0] b, input int mode, input int k1, input int k2);
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] a;
            bit bad;
            a = b + 32'(i * 4);
            bad = (mode == 2) || (mode == 1 && (i == k1 || i == k2)) ||
                  (mode == 3 && $urandom_range(0, 7) == 0);
            gold[i] = $urandom;
            memw[a[7:2]] = gold[i] ^ (bad ? ($urandom | 32'h1) : 32'h0);
        end
    endtask

    task automatic run_sweep(input logic [31:0] b, input bit h, input int abort_at,
                             input int restart_at);
        int cyc;
        @(negedge clk);
        base = b; halt = h; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; busy_cnt = 0; addr_bad = 0; pulses = 0; first_pulse = -1; max_idx = 0;
        while (!o_done && cyc < 300) begin
            if (o_busy) begin
                busy_cnt++;
                if (cyc < DEPTH && (o_addr != b + 32'(cyc * 4) || int'(o_gidx) != cyc))
                    addr_bad++;
                if (int'(o_gidx) > max_idx) max_idx = int'(o_gidx);
            end
            if (o_mm) begin
                pulses++;
                if (first_pulse < 0) first_pulse = cyc;
            end
            if (cyc == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                return;
            end
            start = (cyc == restart_at);
            if (cyc == restart_at) base = b + 32'h100;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Reference: compare word i at address base+4i against gold[i] per the sweep rules.
    task automatic expect_sweep(input string tag, input logic [31:0] b, input bit h);
        int lat, sat, nb, first, e_busy, e_err, e_pulses;
        lat = sel ? 3 : 1;
        sat = sel ? 15 : 65535;
        nb = 0; first = -1;
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] a;
            a = b + 32'(i * 4);
            if (memw[a[7:2]] != gold[i]) begin
                nb++;
                if (first < 0) first = i;
            end
        end
        if (h && first >= 0) begin
            e_busy = first + lat + 1; e_err = 1; e_pulses = 1;
        end else begin
            e_busy = DEPTH + lat; e_err = (nb > sat) ? sat : nb; e_pulses = nb;
        end
        check({tag, ".busy_cycles"}, busy_cnt, e_busy);
        check({tag, ".done"}, o_done, 1);
        check({tag, ".busy_after"}, o_busy, 0);
        check({tag, ".addr_seq_bad"}, addr_bad, 0);
        check({tag, ".err_count"}, o_err, e_err);
        check({tag, ".first_valid"}, o_fev, (first >= 0));
        check({tag, ".first_idx"}, o_fei, (first >= 0) ? first : 0);
        check({tag, ".pulses"}, pulses, e_pulses);
        check({tag, ".pulse_cycle"}, first_pulse, (first >= 0) ? first + lat : -1);
        if (h && first >= 0) check({tag, ".max_issued"}, (max_idx <= first + lat), 1);
    endtask

    initial begin
        logic [31:0] rb;
        bit rh;
        int w;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            check("reset.busy", o_busy, 0);
            check("reset.done", o_done, 0);
            check("reset.addr", o_addr, 0);
            check("reset.err", o_err, 0);
            check("reset.mm", o_mm, 0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        load(32'h0, 0, -1, -1);  run_sweep(32'h0, 1'b0, -1, -1);  expect_sweep("a_clean", 32'h0, 1'b0);
        load(32'h0, 1, 5, -1);   run_sweep(32'h0, 1'b0, -1, -1);  expect_sweep("a_bad5", 32'h0, 1'b0);
        load(32'h0, 1, 10, 30);  run_sweep(32'h0, 1'b1, -1, -1);  expect_sweep("a_halt10", 32'h0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            rb = $urandom & 32'hFFFF_FFFC;
            rh = 1'(($urandom_range(0, 2)) == 0);
            load(rb, 3, -1, -1); run_sweep(rb, rh, -1, -1); expect_sweep("a_rand", rb, rh);
        end

        load(32'h40, 1, 5, -1);
        run_sweep(32'h40, 1'b0, 20, -1);
        check("abort.addr_seq_bad", addr_bad, 0);
        check("abort.busy", o_busy, 0);
        check("abort.done", o_done, 0);
        check("abort.err_kept", o_err, 1);
        run_sweep(32'h40, 1'b0, -1, -1); expect_sweep("a_after_abort", 32'h40, 1'b0);
        run_sweep(32'h40, 1'b0, -1, 10); expect_sweep("a_start_busy", 32'h40, 1'b0);

        sel = 1'b1;
        load(32'hFFFF_FFF0, 1, 3, 60);
        run_sweep(32'hFFFF_FFF0, 1'b0, -1, -1); expect_sweep("b_wrap", 32'hFFFF_FFF0, 1'b0);
        load(32'h100, 2, -1, -1);
        run_sweep(32'h100, 1'b0, -1, -1);       expect_sweep("b_sat", 32'h100, 1'b0);
        load(32'h0, 1, 10, -1);
        run_sweep(32'h0, 1'b1, -1, -1);         expect_sweep("b_halt10", 32'h0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            rb = $urandom & 32'hFFFF_FFFC;
            rh = 1'(($urandom_range(0, 2)) == 0);
            load(rb, 3, -1, -1); run_sweep(rb, rh, -1, -1); expect_sweep("b_rand", rb, rh);
        end

        sel = 1'b0;
        load(32'h0, 1, 5, -1);
        @(negedge clk);
        base = 32'h0; halt = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (o_gidx != 6'd30 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("rst_mid.reached", (w < 200), 1);
        check("rst_mid.err_before", o_err, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid.busy", o_busy, 0);
        check("rst_mid.done", o_done, 0);
        check("rst_mid.addr", o_addr, 0);
        check("rst_mid.gidx", o_gidx, 0);
        check("rst_mid.err", o_err, 0);
        check("rst_mid.fev", o_fev, 0);
        check("rst_mid.fei", o_fei, 0);
        check("rst_mid.mm", o_mm, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid.no_done", o_done, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
